// File: rtl/signed_iter_divider_if.sv
// Handshake bundle for the signed iterative divider: an operand channel
// (dividend/divisor) and a result channel (quotient/remainder/flags),
// each with its own valid/ready pair.
interface signed_iter_divider_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] dividend;
    logic signed [VW-1:0] divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] quotient;
    logic signed [VW-1:0] remainder;
    logic                 div_zero;
    logic                 ovf;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

    // The divider itself.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/signed_iter_divider.sv
// Sequential signed divider. Works on magnitudes with a restoring
// shift-subtract loop (one quotient bit per clock) and applies signs at
// the end. The result truncates toward zero, like Verilog '/' and '%'.
// Divide-by-zero and the single overflowing case (most negative / -1)
// produce saturated quotients with a flag.
module signed_iter_divider #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    signed_iter_divider_if.slave  bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    localparam logic [DW-1:0] Q_MAX_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] Q_MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [DW:0]     mag_reg;       // |dividend|, shifted out MSB first
    logic [VW-1:0]   dvs_reg;       // |divisor|
    logic [VW-1:0]   pr_reg;        // partial remainder magnitude
    logic [DW-1:0]   qm_reg;        // quotient magnitude
    logic            sign_q_reg;
    logic            sign_r_reg;
    logic            dz_reg;
    logic [VW-1:0]   dlo_reg;       // raw low dividend bits for the /0 remainder
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic [DW-1:0]   quotient_reg;
    logic [VW-1:0]   remainder_reg;
    logic            div_zero_reg;
    logic            ovf_reg;

    // Operand magnitudes; DW+1 bits keep the most negative dividend exact.
    logic [DW:0]     dividend_ext;
    logic [DW:0]     dividend_abs;
    logic [VW-1:0]   divisor_abs;
    assign dividend_ext = {bus.dividend[DW-1], bus.dividend};
    assign dividend_abs = bus.dividend[DW-1] ? (~dividend_ext + 1'b1) : dividend_ext;
    assign divisor_abs  = bus.divisor[VW-1] ? (~bus.divisor + 1'b1) : bus.divisor;

    // One restoring step: bring down the next dividend bit and try to subtract.
    logic [VW:0]     pr_shift;
    logic [VW:0]     pr_sub;
    logic            q_bit;
    logic [VW-1:0]   pr_next;
    always_comb begin
        pr_shift = {pr_reg, mag_reg[DW-1]};
        pr_sub   = pr_shift - {1'b0, dvs_reg};
        q_bit    = (pr_shift >= {1'b0, dvs_reg});
        pr_next  = q_bit ? pr_sub[VW-1:0] : pr_shift[VW-1:0];
    end

    // Sign application and saturation for the final result.
    logic [DW-1:0]   q_fix;
    logic [VW-1:0]   r_fix;
    logic            ovf_fix;
    always_comb begin
        q_fix   = qm_reg;
        r_fix   = (sign_r_reg && (pr_reg != '0)) ? (VW'(0) - pr_reg) : pr_reg;
        ovf_fix = 1'b0;
        if (dz_reg) begin
            q_fix = sign_r_reg ? Q_MIN_NEG : Q_MAX_POS;
            r_fix = dlo_reg;
        end else if (!sign_q_reg && qm_reg[DW-1]) begin
            // Only |q| = 2^(DW-1) with a positive sign can get here.
            q_fix   = Q_MAX_POS;
            ovf_fix = 1'b1;
        end else if (sign_q_reg && (qm_reg != '0)) begin
            q_fix = DW'(0) - qm_reg;
        end
    end

    // Control FSM plus datapath registers; all outputs come from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            mag_reg       <= '0;
            dvs_reg       <= '0;
            pr_reg        <= '0;
            qm_reg        <= '0;
            sign_q_reg    <= 1'b0;
            sign_r_reg    <= 1'b0;
            dz_reg        <= 1'b0;
            dlo_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_reg      <= dividend_abs;
                        dvs_reg      <= divisor_abs;
                        sign_q_reg   <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                        sign_r_reg   <= bus.dividend[DW-1];
                        dz_reg       <= (bus.divisor == '0);
                        dlo_reg      <= bus.dividend[VW-1:0];
                        pr_reg       <= '0;
                        qm_reg       <= '0;
                        count_reg    <= CW'(DW-1);
                        in_ready_reg <= 1'b0;
                        state_reg    <= (bus.divisor == '0) ? FIX : DIV;
                    end
                end
                DIV: begin
                    pr_reg  <= pr_next;
                    qm_reg  <= {qm_reg[DW-2:0], q_bit};
                    mag_reg <= {mag_reg[DW-1:0], 1'b0};
                    if (count_reg == '0) begin
                        state_reg <= FIX;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                FIX: begin
                    quotient_reg  <= q_fix;
                    remainder_reg <= r_fix;
                    div_zero_reg  <= dz_reg;
                    ovf_reg       <= ovf_fix;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;
    assign bus.ovf       = ovf_reg;
endmodule
